adder_share_arbiter: RTL

- Time-shares one external 32-bit carry-lookahead adder instance among NUM_REQ requesters.
- Accepts operand triples (A, B, Cin) over per-requester valid/ready handshakes and arbitrates round-robin.
- Drives the adder's registered inputs, waits a programmable settle time, then returns sum, carry-out and signed overflow tagged with the requester ID.
- Sits between client datapaths and the shared adder; the adder itself stays purely combinational.

---
 rtl/adder_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Round-robin front end that time-shares one combinational WIDTH-bit adder
// among NUM_REQ requesters. Each accepted operand triple is registered onto
// the adder inputs, held for SETTLE_CYC cycles, and the sampled sum, carry
// and signed overflow are returned with the owning requester ID.
//
// Optional build macro ADDER_SHARE_ARBITER_OVF_CNT_EN adds a 16-bit
// saturating count (ovf_count) of completed responses that overflowed.

module adder_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 32,
    parameter int SETTLE_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic                       add_cin,
    input  logic [WIDTH-1:0]           add_sum,
    input  logic                       add_cout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_cout,
    output logic                       rsp_ovf,
    output logic                       busy
`ifdef ADDER_SHARE_ARBITER_OVF_CNT_EN
    ,
    output logic [15:0]                ovf_count
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  settle_cnt;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              sel_cin;

    // Round-robin search starting one past the last grant, wrapping at NUM_REQ.
    always_comb begin
        logic [ID_W:0] cand;
        // NOTE: every combinationally assigned variable gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Operand mux for the winning requester, plus the one-hot ready.
    // Ready is also gated by rst_n so nobody sees a handshake while the block is held in reset.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_cin   = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a   = req_a[i*WIDTH +: WIDTH];
                sel_b   = req_b[i*WIDTH +: WIDTH];
                sel_cin = req_cin[i];
            end
        end
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // Control FSM: accept one request, hold the adder inputs, sample, then wait for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            settle_cnt <= '0;
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        add_a      <= sel_a;
                        add_b      <= sel_b;
                        add_cin    <= sel_cin;
                        last_grant <= grant_idx;
                        settle_cnt <= CNT_W'(SETTLE_CYC);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    settle_cnt <= settle_cnt - 1'b1;
                    if (settle_cnt == CNT_W'(1)) begin
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
                        rsp_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != add_a[WIDTH-1]);
                        rsp_id    <= last_grant;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDER_SHARE_ARBITER_OVF_CNT_EN
    // Saturating count of completed responses that reported signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (rsp_valid && rsp_ready && rsp_ovf && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule
